alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_core.sv | 203 ++++++++++++++++++++
 tb/tb_alu_core.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// 16-bit ALU core driven by a start/ready handshake.
// Most ops complete in one EXEC cycle. MUL runs a 16-step shift-add loop.
// DIV and MOD run a 16-step restoring-division loop.
// Operands and opcode are captured on the start edge, so later input changes are ignored.
module alu_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        bgn,
  input  logic [5:0]  opcode,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] acc1,
  output logic [15:0] acc2,
  output logic        zero,
  output logic        negative,
  output logic        carry,
  output logic        overflow,
  output logic        rdy
);

  typedef enum logic [2:0] {IDLE, EXEC, MULT, DIVI, DONE} state_t;

  localparam logic [4:0] OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_LSR = 5'd3,  OP_LSL = 5'd4;
  localparam logic [4:0] OP_RSR = 5'd5,  OP_RSL = 5'd6,  OP_MUL = 5'd7,  OP_DIV = 5'd8;
  localparam logic [4:0] OP_MOD = 5'd9,  OP_AND = 5'd10, OP_OR  = 5'd11, OP_XOR = 5'd12;
  localparam logic [4:0] OP_NOT = 5'd13, OP_CMP = 5'd14, OP_TST = 5'd15, OP_INC = 5'd16;
  localparam logic [4:0] OP_DEC = 5'd17;

  state_t      state_r;
  logic [4:0]  op_r;
  logic [15:0] a_r, b_r;
  logic [15:0] hi_r, lo_r;     // MUL: product high/low; DIVI: remainder/quotient
  logic [4:0]  cnt_r;

  // The immediate flag carries no meaning for this core.
  logic imm_unused_s;
  assign imm_unused_s = opcode[0];

  function automatic logic add_ovf(input logic [15:0] x, input logic [15:0] y, input logic [15:0] r);
    return (x[15] == y[15]) && (r[15] != x[15]);
  endfunction

  function automatic logic sub_ovf(input logic [15:0] x, input logic [15:0] y, input logic [15:0] r);
    return (x[15] != y[15]) && (r[15] != x[15]);
  endfunction

  logic [16:0] add_s, sub_s, inc_s, dec_s;
  logic [31:0] shr_s, shl_s;
  logic [15:0] ex_res_s, ex_a2_s;
  logic        ex_wr1_s, ex_wr2_s, ex_wrf_s, ex_c_s, ex_v_s;
  logic [16:0] mul_sum_s;
  logic [16:0] div_shift_s;
  logic        div_ge_s;
  logic [15:0] div_diff_s;

  // Single-cycle result and flag selection from the captured operands.
  always_comb begin
    add_s    = {1'b0, a_r} + {1'b0, b_r};
    sub_s    = {1'b0, a_r} - {1'b0, b_r};
    inc_s    = {1'b0, a_r} + 17'd1;
    dec_s    = {1'b0, a_r} - 17'd1;
    // The bits just below/above the kept word hold the last bit shifted out.
    shr_s    = {a_r, 16'h0000} >> b_r[3:0];
    shl_s    = {16'h0000, a_r} << b_r[3:0];
    ex_res_s = a_r;
    ex_a2_s  = a_r;
    ex_wr1_s = 1'b0;
    ex_wr2_s = 1'b0;
    ex_wrf_s = 1'b0;
    ex_c_s   = 1'b0;
    ex_v_s   = 1'b0;
    case (op_r)
      OP_ADD: begin ex_res_s = add_s[15:0]; ex_c_s = add_s[16]; ex_v_s = add_ovf(a_r, b_r, add_s[15:0]); ex_wr1_s = 1'b1; ex_wrf_s = 1'b1; end
      OP_SUB: begin ex_res_s = sub_s[15:0]; ex_c_s = sub_s[16]; ex_v_s = sub_ovf(a_r, b_r, sub_s[15:0]); ex_wr1_s = 1'b1; ex_wrf_s = 1'b1; end
      OP_CMP: begin ex_res_s = sub_s[15:0]; ex_c_s = sub_s[16]; ex_v_s = sub_ovf(a_r, b_r, sub_s[15:0]); ex_wrf_s = 1'b1; end
      OP_INC: begin ex_res_s = inc_s[15:0]; ex_c_s = inc_s[16]; ex_v_s = add_ovf(a_r, 16'h0001, inc_s[15:0]); ex_wr1_s = 1'b1; ex_wrf_s = 1'b1; end
      OP_DEC: begin ex_res_s = dec_s[15:0]; ex_c_s = dec_s[16]; ex_v_s = sub_ovf(a_r, 16'h0001, dec_s[15:0]); ex_wr1_s = 1'b1; ex_wrf_s = 1'b1; end
      OP_LSR: begin ex_res_s = shr_s[31:16]; ex_c_s = shr_s[15]; ex_wr1_s = 1'b1; ex_wrf_s = 1'b1; end
      OP_LSL: begin ex_res_s = shl_s[15:0]; ex_c_s = shl_s[16]; ex_wr1_s = 1'b1; ex_wrf_s = 1'b1; end
      OP_RSR: begin ex_res_s = shr_s[31:16] | shr_s[15:0]; ex_c_s = shr_s[15]; ex_wr1_s = 1'b1; ex_wrf_s = 1'b1; end
      OP_RSL: begin ex_res_s = shl_s[15:0] | shl_s[31:16]; ex_c_s = shl_s[16]; ex_wr1_s = 1'b1; ex_wrf_s = 1'b1; end
      OP_AND: begin ex_res_s = a_r & b_r; ex_wr1_s = 1'b1; ex_wrf_s = 1'b1; end
      OP_OR:  begin ex_res_s = a_r | b_r; ex_wr1_s = 1'b1; ex_wrf_s = 1'b1; end
      OP_XOR: begin ex_res_s = a_r ^ b_r; ex_wr1_s = 1'b1; ex_wrf_s = 1'b1; end
      OP_NOT: begin ex_res_s = ~a_r; ex_wr1_s = 1'b1; ex_wrf_s = 1'b1; end
      OP_TST: begin ex_res_s = a_r & b_r; ex_wrf_s = 1'b1; end
      // DIV/MOD only reach EXEC with a zero divisor.
      OP_DIV, OP_MOD: begin
        ex_res_s = 16'hFFFF; ex_a2_s = a_r; ex_v_s = 1'b1;
        ex_wr1_s = 1'b1; ex_wr2_s = 1'b1; ex_wrf_s = 1'b1;
      end
      default: begin ex_wr1_s = 1'b0; ex_wr2_s = 1'b0; ex_wrf_s = 1'b0; end
    endcase
  end

  // One shift-add step and one restoring-division step, both based on the loop registers.
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : 17'd0);
    div_shift_s = {hi_r, lo_r[15]};
    div_ge_s    = (div_shift_s >= {1'b0, b_r});
    div_diff_s  = div_shift_s[15:0] - b_r;
  end

  // Control FSM, operand capture, iteration and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      op_r     <= 5'd0;
      a_r      <= 16'h0000;
      b_r      <= 16'h0000;
      hi_r     <= 16'h0000;
      lo_r     <= 16'h0000;
      cnt_r    <= 5'd0;
      acc1     <= 16'h0000;
      acc2     <= 16'h0000;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      rdy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bgn) begin
            op_r  <= opcode[5:1];
            a_r   <= A;
            b_r   <= B;
            cnt_r <= 5'd0;
            hi_r  <= 16'h0000;
            if (opcode[5:1] == OP_MUL) begin
              lo_r    <= B;
              state_r <= MULT;
            end else if ((opcode[5:1] == OP_DIV || opcode[5:1] == OP_MOD) && B != 16'h0000) begin
              lo_r    <= A;
              state_r <= DIVI;
            end else begin
              state_r <= EXEC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          if (ex_wr1_s) acc1 <= ex_res_s;
          if (ex_wr2_s) acc2 <= ex_a2_s;
          if (ex_wrf_s) begin
            zero     <= (ex_res_s == 16'h0000);
            negative <= ex_res_s[15];
            carry    <= ex_c_s;
            overflow <= ex_v_s;
          end
          rdy     <= 1'b1;
          state_r <= DONE;
        end
        MULT: begin
          if (cnt_r == 5'd16) begin
            acc1     <= lo_r;
            acc2     <= hi_r;
            zero     <= ({hi_r, lo_r} == 32'h0000_0000);
            negative <= lo_r[15];
            carry    <= (hi_r != 16'h0000);
            overflow <= (hi_r != 16'h0000);
            rdy      <= 1'b1;
            state_r  <= DONE;
          end else begin
            hi_r  <= mul_sum_s[16:1];
            lo_r  <= {mul_sum_s[0], lo_r[15:1]};
            cnt_r <= cnt_r + 5'd1;
          end
        end
        DIVI: begin
          if (cnt_r == 5'd16) begin
            acc1     <= (op_r == OP_DIV) ? lo_r : hi_r;
            acc2     <= (op_r == OP_DIV) ? hi_r : lo_r;
            zero     <= (((op_r == OP_DIV) ? lo_r : hi_r) == 16'h0000);
            negative <= (op_r == OP_DIV) ? lo_r[15] : hi_r[15];
            carry    <= 1'b0;
            overflow <= 1'b0;
            rdy      <= 1'b1;
            state_r  <= DONE;
          end else begin
            hi_r  <= div_ge_s ? div_diff_s : div_shift_s[15:0];
            lo_r  <= {lo_r[14:0], div_ge_s};
            cnt_r <= cnt_r + 5'd1;
          end
        end
        DONE: begin
          if (!bgn) begin
            rdy     <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          rdy     <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard testbench for alu_core.
// Expected results come from an arithmetic reference model and are queued at issue.
// A separate monitor checks each rising edge of rdy against the head of the queue.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bgn = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [15:0] A = 16'h0000, B = 16'h0000;
  logic [15:0] acc1, acc2;
  logic        zero, negative, carry, overflow, rdy;

  alu_core dut (
    .clk(clk), .rst(rst), .bgn(bgn), .opcode(opcode), .A(A), .B(B),
    .acc1(acc1), .acc2(acc2), .zero(zero), .negative(negative),
    .carry(carry), .overflow(overflow), .rdy(rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a1, a2;
    logic        z, n, c, v;
    int          when;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_fail = 0;

  // Reference architectural state.
  logic [15:0] m_a1 = 16'h0000, m_a2 = 16'h0000;
  logic        m_z = 1'b0, m_n = 1'b0, m_c = 1'b0, m_v = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_res(input int unsigned r);
    m_a1 = r[15:0];
    m_z  = (r[15:0] == 16'h0000);
    m_n  = r[15];
  endtask

  // Reference model: apply one operation to the model state and return its latency.
  task automatic apply_model(input logic [4:0] op, input logic [15:0] a16, input logic [15:0] b16, output int lat);
    int unsigned a, b, n, r, p;
    int sa, sb, sr;
    a = a16; b = b16; n = b & 15;
    sa = $signed(a16); sb = $signed(b16);
    lat = 1;
    case (op)
      5'd1, 5'd16: begin
        if (op == 5'd16) begin b = 1; sb = 1; end
        r = a + b; sr = sa + sb;
        set_res(r); m_c = (r > 65535); m_v = (sr > 32767) || (sr < -32768);
      end
      5'd2, 5'd14, 5'd17: begin
        if (op == 5'd17) begin b = 1; sb = 1; end
        r = a - b; sr = sa - sb;
        if (op == 5'd14) begin m_z = (r[15:0] == 16'h0000); m_n = r[15]; end
        else set_res(r);
        m_c = (a < b); m_v = (sr > 32767) || (sr < -32768);
      end
      5'd3: begin set_res(a >> n); m_c = (n == 0) ? 1'b0 : ((a >> (n - 1)) & 1) == 1; m_v = 1'b0; end
      5'd4: begin set_res(a << n); m_c = (n == 0) ? 1'b0 : ((a >> (16 - n)) & 1) == 1; m_v = 1'b0; end
      5'd5: begin set_res((a >> n) | (a << (16 - n))); m_c = (n == 0) ? 1'b0 : ((a >> (n - 1)) & 1) == 1; m_v = 1'b0; end
      5'd6: begin set_res((a << n) | (a >> (16 - n))); m_c = (n == 0) ? 1'b0 : ((a >> (16 - n)) & 1) == 1; m_v = 1'b0; end
      5'd7: begin
        p = a * b; lat = 17;
        m_a1 = p[15:0]; m_a2 = p[31:16];
        m_z = (p == 0); m_n = p[15]; m_c = (p[31:16] != 16'h0000); m_v = m_c;
      end
      5'd8, 5'd9: begin
        if (b == 0) begin
          m_a1 = 16'hFFFF; m_a2 = a16; m_z = 1'b0; m_n = 1'b1; m_c = 1'b0; m_v = 1'b1;
        end else begin
          lat = 17;
          if (op == 5'd8) begin set_res(a / b); m_a2 = a % b; end
          else begin set_res(a % b); m_a2 = a / b; end
          m_c = 1'b0; m_v = 1'b0;
        end
      end
      5'd10: begin set_res(a & b); m_c = 1'b0; m_v = 1'b0; end
      5'd11: begin set_res(a | b); m_c = 1'b0; m_v = 1'b0; end
      5'd12: begin set_res(a ^ b); m_c = 1'b0; m_v = 1'b0; end
      5'd13: begin set_res(~a); m_c = 1'b0; m_v = 1'b0; end
      5'd15: begin r = a & b; m_z = (r[15:0] == 16'h0000); m_n = r[15]; m_c = 1'b0; m_v = 1'b0; end
      default: lat = 1;
    endcase
  endtask

  // Issue one operation, scramble inputs after capture, wait for rdy, hold, release.
  task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
    exp_t e;
    int   lat, t;
    @(negedge clk);
    opcode = {op, $urandom_range(0, 1) == 1};
    A = a; B = b; bgn = 1'b1;
    apply_model(op, a, b, lat);
    e.a1 = m_a1; e.a2 = m_a2; e.z = m_z; e.n = m_n; e.c = m_c; e.v = m_v;
    e.when = cyc + 1 + lat;
    sb_q.push_back(e);
    @(posedge clk); #1;
    A = $urandom; B = $urandom; opcode = $urandom;
    t = 0;
    do begin @(negedge clk); t++; end while (!rdy && t < 40);
    if (!rdy) begin
      n_vec++; n_fail++;
      $display("FAIL rdy_timeout: no rdy after %0d cycles for op %0d", t, op);
    end
    repeat (hold) @(negedge clk);
    bgn = 1'b0;
    @(negedge clk);
    check("rdy_drop", {31'd0, rdy}, 32'd0);
  endtask

  // Monitor: each rising rdy is one completion, compared against the queue head.
  initial begin
    logic rdy_q;
    exp_t e;
    rdy_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) rdy_q = 1'b0;
      else begin
        if (rdy && !rdy_q) begin
          if (sb_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL extra_completion: rdy rose at cycle %0d, expected none", cyc);
          end else begin
            e = sb_q.pop_front();
            check("latency_cycle", cyc, e.when);
            check("acc1", {16'd0, acc1}, {16'd0, e.a1});
            check("acc2", {16'd0, acc2}, {16'd0, e.a2});
            check("flags_zncv", {28'd0, zero, negative, carry, overflow}, {28'd0, e.z, e.n, e.c, e.v});
          end
        end
        rdy_q = rdy;
      end
    end
  end

  initial begin
    logic [4:0]  op;
    logic [15:0] ra, rb;
    repeat (3) @(negedge clk);
    check("reset_acc", {acc1, acc2}, 32'd0);
    check("reset_flags_rdy", {27'd0, zero, negative, carry, overflow, rdy}, 32'd0);
    rst = 1'b0;

    // Directed cases
    run_op(5'd1,  16'h7FFF, 16'h0001, 0);  // ADD overflow
    run_op(5'd2,  16'h0003, 16'h0005, 0);  // SUB borrow
    run_op(5'd14, 16'h0003, 16'h0005, 0);  // CMP same operands
    run_op(5'd7,  16'hFFFF, 16'hFFFF, 0);  // MUL max
    run_op(5'd8,  16'h0064, 16'h0007, 0);  // DIV
    run_op(5'd9,  16'h0064, 16'h0007, 0);  // modulo remainder
    run_op(5'd8,  16'h0064, 16'h0000, 0);  // DIV by zero
    run_op(5'd6,  16'h8001, 16'h0001, 0);  // RSL
    run_op(5'd4,  16'hA5A5, 16'h0000, 0);  // LSL by zero
    run_op(5'd16, 16'h7FFF, 16'h0000, 0);  // INC overflow
    run_op(5'd17, 16'h0000, 16'h1234, 0);  // DEC borrow
    run_op(5'd0,  16'h1111, 16'h2222, 0);  // unsupported
    run_op(5'd31, 16'h3333, 16'h4444, 0);  // unsupported
    run_op(5'd12, 16'hF0F0, 16'h0FF0, 5);  // bgn held in DONE

    // Reset during MUL aborts the operation
    @(negedge clk);
    opcode = {5'd7, 1'b0}; A = 16'h1234; B = 16'h5678; bgn = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1; bgn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midmul_reset_acc", {acc1, acc2}, 32'd0);
    check("midmul_reset_flags_rdy", {27'd0, zero, negative, carry, overflow, rdy}, 32'd0);
    m_a1 = 16'h0000; m_a2 = 16'h0000; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
    repeat (25) @(negedge clk);
    check("no_completion_after_abort", {31'd0, rdy}, 32'd0);

    // Randomized operations
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 31);
      if ($urandom_range(0, 3) != 0) op = $urandom_range(1, 17);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'h7FFF;
      run_op(op, ra, rb, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
